// File: rtl/mem_access_stage.sv
// Data-memory access stage: lane steering, load formatting and timeout; MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: dmem_req the cycle after acceptance; done_m and load_data_m the cycle after dmem_ack.
// Backpressure: stall_m holds the pipeline while an access is accepted or outstanding; it drops in RESP/FAULT.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_m,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic [2:0]  funct3_m,
   input  logic [31:0] addr_m,
   input  logic [31:0] wd_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data_m,
   output logic        stall_m,
   output logic        done_m,
   output logic        fault_m,
   output logic [1:0]  fault_cause
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP, FAULT} state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] tmo_cnt;
   logic [1:0]    lane_q;
   logic [2:0]    f3_q;

   logic          new_acc, is_half, is_word, trap_hit;
   logic [1:0]    lane_n;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n, ld_fmt;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;

   assign new_acc = valid_m & (mem_read_m | mem_write_m);
   assign is_word = funct3_m[1];
   assign is_half = ~funct3_m[1] & funct3_m[0];

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = (is_half & addr_m[0]) | (is_word & (addr_m[1:0] != 2'b00));
   assign trap_hit   = misaligned;
`else
   assign trap_hit   = 1'b0;
`endif

   // Misaligned accesses that are not trapped fall back to natural alignment.
   always_comb begin
      lane_n  = addr_m[1:0];
      be_n    = 4'b1111;
      wdata_n = wd_m;
      if (is_word) begin
         lane_n = 2'b00;
      end else if (is_half) begin
         lane_n[0] = 1'b0;
         be_n      = addr_m[1] ? 4'b1100 : 4'b0011;
         wdata_n   = {2{wd_m[15:0]}};
      end else begin
         be_n    = 4'b0001 << addr_m[1:0];
         wdata_n = {4{wd_m[7:0]}};
      end
   end

   assign ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
   assign ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (f3_q)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'd0, ld_byte};
         3'b101:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = dmem_rdata;
      endcase
   end

   assign stall_m = ((state == IDLE) & new_acc) | (state == BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         lane_q      <= 2'b00;
         f3_q        <= 3'b000;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= 32'd0;
         dmem_wdata  <= 32'd0;
         dmem_be     <= 4'b0000;
         load_data_m <= 32'd0;
         done_m      <= 1'b0;
         fault_m     <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         done_m      <= 1'b0;
         fault_m     <= 1'b0;
         fault_cause <= 2'b00;
         case (state)
            IDLE: begin
               if (new_acc && trap_hit) begin
                  state       <= FAULT;
                  done_m      <= 1'b1;
                  fault_m     <= 1'b1;
                  fault_cause <= mem_write_m ? 2'b10 : 2'b01;
               end else if (new_acc) begin
                  state      <= BUSY;
                  tmo_cnt    <= '0;
                  lane_q     <= lane_n;
                  f3_q       <= funct3_m;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write_m;
                  dmem_addr  <= {addr_m[31:2], 2'b00};
                  dmem_be    <= be_n;
                  dmem_wdata <= wdata_n;
               end
            end
            BUSY: begin
               tmo_cnt <= tmo_cnt + CW'(1);
               // An ack in the expiry cycle still wins over the timeout.
               if (dmem_ack) begin
                  state    <= RESP;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  done_m   <= 1'b1;
                  if (!dmem_we) load_data_m <= ld_fmt;
               end else if (tmo_cnt == TMO_LAST) begin
                  state       <= FAULT;
                  dmem_req    <= 1'b0;
                  dmem_we     <= 1'b0;
                  done_m      <= 1'b1;
                  fault_m     <= 1'b1;
                  fault_cause <= 2'b11;
               end
            end
            RESP:    state <= IDLE;
            FAULT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage; the expected result of each access is
// pushed when it is issued and checked by an independent monitor when done_m appears.
module tb_mem_access_stage;
   localparam int TMO = 16;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid_m = 1'b0, mem_read_m = 1'b0, mem_write_m = 1'b0;
   logic [2:0]  funct3_m = 3'd0;
   logic [31:0] addr_m = 32'd0, wd_m = 32'd0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic [31:0] load_data_m;
   logic        stall_m, done_m, fault_m;
   logic [1:0]  fault_cause;

   mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .valid_m(valid_m), .mem_read_m(mem_read_m),
      .mem_write_m(mem_write_m), .funct3_m(funct3_m), .addr_m(addr_m), .wd_m(wd_m),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .load_data_m(load_data_m), .stall_m(stall_m),
      .done_m(done_m), .fault_m(fault_m), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          req_cycles;
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0, n_fail = 0;
   logic [31:0] ld_ref = 32'd0;
   logic [31:0] cur_rdata = 32'd0;
   int          cur_ack_at = 0;
   bit          orphan_ok = 1'b0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Memory: acks on the cur_ack_at-th request cycle (0 = never); stray acks while idle.
   initial begin
      int bc = 0;
      forever begin
         @(negedge clk);
         if (dmem_req) begin
            bc++;
            dmem_ack   = (bc == cur_ack_at);
            dmem_rdata = dmem_ack ? cur_rdata : $urandom;
         end else begin
            bc = 0;
            dmem_ack   = ($urandom % 4) == 0;
            dmem_rdata = $urandom;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      int          req_cnt = 0;
      bit          prev_req = 0, prev_done = 0;
      logic [68:0] rec = '0;
      exp_t        e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            req_cnt = 0; prev_req = 0; prev_done = 0;
            continue;
         end
         if (dmem_req) begin
            chk("stall_in_busy", stall_m, 1'b1);
            if (req_cnt == 0) begin
               chk("req_has_txn", (exp_q.size() != 0) || orphan_ok, 1'b1);
               rec = {dmem_addr, dmem_we, dmem_be, dmem_wdata};
            end else begin
               chk("req_stable", {dmem_addr, dmem_we, dmem_be, dmem_wdata}, rec);
            end
            req_cnt++;
         end
         if (!fault_m) chk("cause_zero", fault_cause, 2'b00);
         else          chk("fault_has_done", done_m, 1'b1);
         if (done_m) begin
            chk("done_has_txn", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("req_cycles", req_cnt, e.req_cycles);
               chk("done_after_req", prev_req, e.req_cycles > 0);
               chk("fault_m", fault_m, e.fault);
               chk("fault_cause", fault_cause, e.cause);
               if (e.req_cycles > 0) begin
                  chk("dmem_addr", rec[68:37], e.addr);
                  chk("dmem_we", rec[36], e.we);
                  if (e.we) begin
                     chk("dmem_be", rec[35:32], e.be);
                     chk("dmem_wdata", rec[31:0], e.wdata);
                  end
               end
               chk("load_data", load_data_m, e.ld);
            end
            chk("stall_in_done", stall_m, 1'b0);
            chk("done_pulse", prev_done, 1'b0);
            req_cnt = 0;
         end
         prev_req  = dmem_req;
         prev_done = done_m;
      end
   end

   // Reference model: byte-level arithmetic on the access, not on signal structure.
   task automatic issue(bit wr, bit both, logic [2:0] f3, logic [31:0] addr,
                        logic [31:0] wd, logic [31:0] rdata, int ack_at);
      exp_t        e;
      int          size, off;
      logic [31:0] eff, lv, mask;
      bit          got = 0;
      size = f3[1] ? 4 : (f3[0] ? 2 : 1);
      e = '{req_cycles: 0, fault: 1'b0, cause: 2'b00, addr: 32'd0, we: 1'b0,
            be: 4'd0, wdata: 32'd0, ld: 32'd0};
      if (TRAP && (addr % size) != 0) begin
         e.fault = 1'b1;
         e.cause = wr ? 2'b10 : 2'b01;
      end else begin
         eff     = addr - (addr % size);
         off     = int'(eff % 4);
         e.addr  = eff - off;
         e.we    = wr;
         e.be    = 4'(((1 << size) - 1) << off);
         e.wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                   (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
         if (ack_at == 0) begin
            e.req_cycles = TMO;
            e.fault      = 1'b1;
            e.cause      = 2'b11;
         end else begin
            e.req_cycles = ack_at;
            if (!wr) begin
               lv = rdata >> (8 * off);
               if (size < 4) begin
                  mask = (32'd1 << (8 * size)) - 32'd1;
                  lv   = lv & mask;
                  if (!f3[2] && lv[8*size-1]) lv = lv | ~mask;
               end
               ld_ref = lv;
            end
         end
      end
      e.ld = ld_ref;
      exp_q.push_back(e);
      cur_rdata  = rdata;
      cur_ack_at = ack_at;
      @(negedge clk);
      valid_m = 1'b1; mem_write_m = wr; mem_read_m = !wr || both;
      funct3_m = f3; addr_m = addr; wd_m = wd;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_m) begin
            got = 1;
            break;
         end
      end
      valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
      chk("done_seen", got, 1'b1);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         valid_m     = 1'($urandom % 2);
         mem_read_m  = !valid_m && ($urandom % 2 == 1);
         mem_write_m = 1'b0;
         addr_m      = $urandom;
      end
   endtask

   initial begin
      bit          wr;
      int          k, r, ack_at;
      logic [2:0]  f3;
      repeat (2) @(negedge clk);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_dmem_we", dmem_we, 1'b0);
      chk("rst_dmem_be", dmem_be, 4'b0000);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      chk("rst_load_data", load_data_m, 32'd0);
      chk("rst_stall_done_fault", {stall_m, done_m, fault_m, fault_cause}, 5'd0);
      reset = 1'b1;
      idle(2);

      // LB at 0x103, ack on first request cycle
      issue(0, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1);
      chk("lb_0x103_data", load_data_m, 32'hFFFF_FF80);
      // SH at 0x202 -> upper lanes, replicated halfword; load data untouched
      issue(1, 0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_1111, 2);
      chk("sh_keeps_load", load_data_m, 32'hFFFF_FF80);
      // LW with ack withheld -> timeout fault after TMO request cycles
      issue(0, 0, 3'b010, 32'h0000_0300, 32'd0, 32'h2222_2222, 0);
      // LW at 0x101: trapped or aligned down to 0x100
      issue(0, 0, 3'b010, 32'h0000_0101, 32'd0, 32'h1234_5678, 1);
      // Ack arrives exactly as the timeout expires
      issue(0, 0, 3'b010, 32'h0000_0400, 32'd0, 32'hCAFE_F00D, TMO);
      chk("ack_at_expiry_data", load_data_m, 32'hCAFE_F00D);

      // Reset three cycles into an outstanding access
      orphan_ok  = 1'b1;
      cur_ack_at = 0;
      @(negedge clk);
      valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0;
      funct3_m = 3'b010; addr_m = 32'h0000_0040;
      repeat (3) @(negedge clk);
      chk("busy_before_reset", dmem_req, 1'b1);
      reset = 1'b0;
      valid_m = 1'b0; mem_read_m = 1'b0;
      #1;
      chk("reset_drops_req", dmem_req, 1'b0);
      chk("reset_no_done", {done_m, stall_m}, 2'b00);
      repeat (2) begin
         @(negedge clk);
         chk("in_reset_no_done", done_m, 1'b0);
      end
      ld_ref = 32'd0;
      reset = 1'b1;
      orphan_ok = 1'b0;
      issue(1, 1, 3'b010, 32'h0000_0080, 32'hDEAD_BEEF, 32'd0, 2);

      for (int t = 0; t < 150; t++) begin
         wr = 1'($urandom % 2);
         k  = $urandom % 5;
         f3 = wr ? 3'($urandom % 3) : 3'(k < 3 ? k : k + 1);
         r  = $urandom % 16;
         ack_at = (r == 0) ? 0 : (r == 1) ? TMO : 1 + ($urandom % 4);
         issue(wr, wr && ($urandom % 2 == 1), f3, $urandom, $urandom, $urandom, ack_at);
         idle($urandom % 3);
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of BUSY cycles without dmem_ack before a timeout fault.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port valid_m  input  1  the MEM-stage instruction is valid.
REQ-005 SHALL have ports mem_read_m and mem_write_m  input  1 each  load and store request.
REQ-006 SHALL have port funct3_m  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 SHALL have ports addr_m and wd_m  input  32 each  byte address and raw store data from the EX/MEM register.
REQ-008 SHALL have ports dmem_req and dmem_we  output  1 each  memory request and write strobe.
REQ-009 SHALL have ports dmem_addr and dmem_wdata  output  32 each  word-aligned address (bits[1:0]=00) and lane-replicated store data.
REQ-010 SHALL have port dmem_be  output  4  byte enables.
REQ-011 SHALL have ports dmem_ack  input  1 and dmem_rdata  input  32  memory response.
REQ-012 SHALL have port load_data_m  output  32  formatted load result.
REQ-013 SHALL have ports stall_m and done_m  output  1 each  pipeline hold and completion pulse.
REQ-014 SHALL have ports fault_m  output  1 and fault_cause  output  2  fault flag and cause: 01 misaligned load, 10 misaligned store, 11 timeout.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY, RESP and FAULT.
REQ-016 SHALL, in IDLE with valid_m and (mem_read_m or mem_write_m), register the address, size, data and strobe and enter BUSY on the next edge; otherwise it stays in IDLE.
REQ-017 SHALL give mem_write_m priority when both mem_read_m and mem_write_m are asserted.
REQ-018 SHALL hold dmem_req=1 and keep dmem_addr, dmem_we, dmem_be and dmem_wdata stable throughout BUSY, and hold dmem_req=0 in every other state.
REQ-019 SHALL, on dmem_ack in BUSY, capture the formatted dmem_rdata for loads and enter RESP.
REQ-020 SHALL remain in RESP for exactly one cycle, assert done_m there, then return to IDLE.
REQ-021 SHALL drive stall_m = (IDLE and a new access is present) or BUSY, so that stall_m is 0 in RESP and the pipeline advances.
REQ-022 SHALL produce latency as follows: access seen in cycle N, dmem_req high from N+1, dmem_ack in cycle K, done_m and load_data_m valid in cycle K+1.
REQ-023 SHALL hold load_data_m until the next load completes, and leave it unchanged on stores.
REQ-024 SHALL generate store lanes as follows: SB -> be=0001<<addr[1:0] with the byte replicated x4; SH -> be=0011 (addr[1]=0) or 1100 (addr[1]=1) with the halfword replicated x2; SW -> be=1111.
REQ-025 SHALL format loads by selecting the lane given by addr[1:0] and sign-extending (LB/LH) or zero-extending (LBU/LHU); LW passes through unchanged.
REQ-026 SHALL increment a timeout counter every BUSY cycle, clear it on BUSY entry, and enter FAULT with cause 11 when the count reaches TIMEOUT_CYCLES with no dmem_ack.
REQ-027 SHALL, in FAULT, assert fault_m and done_m for one cycle with stall_m=0, then return to IDLE.
REQ-028 SHALL give dmem_ack priority over timeout expiry when both occur in the same cycle.
REQ-029 SHALL ignore dmem_ack outside BUSY.
REQ-030 SHALL hold fault_cause at 00 whenever fault_m=0.

Reset
REQ-031 SHALL, on reset low, immediately force IDLE and set dmem_req, dmem_we, stall_m, done_m and fault_m to 0, dmem_be to 0000, dmem_addr, dmem_wdata and load_data_m to 0, fault_cause to 00, and the counter to 0.
REQ-032 SHALL abandon an in-flight BUSY access on reset without asserting done_m, and resume in IDLE after reset releases.

Configuration
REQ-033 SHALL, with MISALIGN_TRAP_EN defined, detect halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=00, issue no memory request for them, and enter FAULT on the next edge with cause 01 (load) or 10 (store).
REQ-034 SHALL, without MISALIGN_TRAP_EN, force misaligned accesses to natural alignment (addr[0] cleared for halfword, addr[1:0] cleared for word) and never raise causes 01 or 10.

Verification
REQ-035 SHALL cover: LB at addr 0x103, dmem_rdata=0x80FF_1234, ack on the first BUSY cycle -> dmem_addr=0x100, load_data_m=0xFFFF_FF80, done_m high 2 cycles after the request.
REQ-036 SHALL cover: SH at addr 0x202, wd_m=0x0000_ABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1.
REQ-037 SHALL cover: LW with ack withheld and TIMEOUT_CYCLES=16 -> 16 cycles of dmem_req, then fault_m=1 with fault_cause=11 for one cycle, then IDLE.
REQ-038 SHALL cover: LW at 0x101 with MISALIGN_TRAP_EN -> dmem_req never asserted and fault_cause=01; without the macro -> access to 0x100 completes normally.
REQ-039 SHALL cover: reset asserted 3 cycles into BUSY -> dmem_req drops the same cycle, no done_m, and a following SW completes normally.
REQ-040 SHALL cover: dmem_ack asserted on the same cycle the timeout expires -> RESP is taken with no fault.
